// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load handshake and display scan signal bundle for seg_scan_ctrl
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [3:0]              bcd;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [IW-1:0]           scan_idx;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  bcd,
        input  dig_en,
        input  scan_idx
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output bcd,
        output dig_en,
        output scan_idx
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multi-digit 7-segment scan controller with blanking guard; optional SEG_SCAN_LZB_EN leading-zero blanking
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    seg_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DW-1:0]         disp, disp_nxt, pend;
    logic                  pend_vld;
    logic                  accept, apply, enter_blank;
    logic [3:0]            bcd_r, bcd_nxt;
    logic [NUM_DIGITS-1:0] dig_en_r, dig_en_nxt;

    // Word as it will be held in disp; with blanking, leading zeros become code F
    function automatic logic [DW-1:0] format_word(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = w;
`ifdef SEG_SCAN_LZB_EN
        begin : lzb
            logic lead;
            lead = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (lead && w[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    // Slot sequencing, frame-boundary word swap and next output values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (enable) state_nxt = BLANK;
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping enable abandons the slot wherever it is
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end

        enter_blank = (state_nxt == BLANK) && (state != BLANK);
        accept      = bus.load_valid && !pend_vld;
        // Swap only at a frame start (or while idle) so a frame never mixes two words
        apply       = pend_vld && ((state == IDLE) || (enter_blank && idx_nxt == '0));
        disp_nxt    = apply ? format_word(pend) : disp;

        dig_en_nxt = '0;
        bcd_nxt    = bcd_r;
        if (state_nxt == IDLE) bcd_nxt = 4'hF;
        else if (enter_blank) bcd_nxt = disp_nxt[4*idx_nxt +: 4];
        else if (state_nxt == SHOW) dig_en_nxt = NUM_DIGITS'(1) << idx_nxt;
    end

    // State, counters, display/pending words and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            disp     <= '1;
            pend     <= '0;
            pend_vld <= 1'b0;
            bcd_r    <= 4'hF;
            dig_en_r <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            disp     <= disp_nxt;
            bcd_r    <= bcd_nxt;
            dig_en_r <= dig_en_nxt;
            if (accept) begin
                pend     <= bus.load_data;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign bus.load_ready = !pend_vld;
    assign bus.bcd        = bcd_r;
    assign bus.dig_en     = dig_en_r;
    assign bus.scan_idx   = idx;
endmodule
